// File: rtl/rf_scan_reader_if.sv
// Bus between the register-file scan reader, the RF read port and the display path.
// disp_valid/disp_ready: an offer is held stable until disp_valid and disp_ready are both high at a clk edge.
interface rf_scan_reader_if;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] disp_data;
  logic [4:0]  disp_idx;
  logic        disp_valid;
  logic        disp_ready;

  modport master (
    output rf_addr,
    input  rf_data,
    output disp_data,
    output disp_idx,
    output disp_valid,
    input  disp_ready
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  disp_data,
    input  disp_idx,
    input  disp_valid,
    output disp_ready
  );
endinterface

// File: rtl/rf_scan_reader.sv
// Walks RF read addresses 0..31, offers each value to the display, then holds it
// for HOLD_CYCLES cycles with pause and single-step control.
module rf_scan_reader #(
  parameter logic [31:0] HOLD_CYCLES = 32'd25_000_000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             pause,
  input  logic             step,
  rf_scan_reader_if.master bus,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_OFFER = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e      state_q;
  logic [4:0]  idx_q;
  logic [4:0]  disp_idx_q;
  logic [31:0] disp_data_q;
  logic [31:0] hold_cnt_q;
  logic        disp_valid_q;
  logic        step_q;

  logic [4:0]  idx_d;
  logic [31:0] hold_cnt_d;
  logic        hold_done_d;
  logic        step_rise_d;

  // The index wraps 31 -> 0 through plain 5-bit overflow.
  assign idx_d       = idx_q + 5'd1;
  assign hold_cnt_d  = hold_cnt_q + 32'd1;
  assign hold_done_d = (hold_cnt_q == HOLD_CYCLES - 32'd1);
  assign step_rise_d = step & ~step_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      hold_cnt_q   <= '0;
      step_q       <= 1'b0;
      disp_data_q  <= '0;
      disp_idx_q   <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      step_q <= step;
      if (!en) begin
        // Dropping enable keeps idx and the last shown value; re-enable rereads idx.
        state_q      <= S_IDLE;
        disp_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_READ;
          S_READ: begin
            disp_data_q  <= bus.rf_data;
            disp_idx_q   <= idx_q;
            disp_valid_q <= 1'b1;
            state_q      <= S_OFFER;
          end
          S_OFFER: begin
            if (bus.disp_ready) begin
              disp_valid_q <= 1'b0;
              hold_cnt_q   <= '0;
              state_q      <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!pause) begin
              hold_cnt_q <= hold_cnt_d;
              if (hold_done_d) begin
                idx_q   <= idx_d;
                state_q <= S_READ;
              end
            end else if (step_rise_d) begin
              // Stepping leaves hold_cnt alone; it restarts on the next acceptance.
              idx_q   <= idx_d;
              state_q <= S_READ;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rf_addr    = idx_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_idx   = disp_idx_q;
  assign bus.disp_valid = disp_valid_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rf_scan_reader.sv
// Bench for rf_scan_reader: directed scenarios plus random stimulus, all checked
// against an offer-level behavioural model of the scan sequence.
module tb_rf_scan_reader;
  localparam logic [31:0] HOLD = 32'd4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rstn, en, pause, step, busy;
  logic [1:0]  dbg_state;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  rf_scan_reader_if bus();

  rf_scan_reader #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .pause       (pause),
    .step        (step),
    .bus         (bus.master),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Register file: r0 reads as zero, writes land at the clock edge.
  logic [31:0] rf [32];
  assign bus.rf_data = (bus.rf_addr == 5'd0) ? 32'd0 : rf[bus.rf_addr];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scanner is either off, about to read, offering, or counting down a hold.
  bit          m_on = 1'b0, m_read = 1'b0, m_valid = 1'b0, m_step_prev = 1'b0;
  logic [4:0]  m_idx = '0, m_didx = '0;
  logic [31:0] m_data = '0;
  int          m_left = 0;
  logic [36:0] exp_q[$];

  always @(posedge clk) begin
    bit step_rise;
    cyc++;
    if (!rstn) begin
      m_on = 0; m_read = 0; m_valid = 0; m_step_prev = 0;
      m_idx = '0; m_didx = '0; m_data = '0; m_left = 0;
    end else begin
      step_rise   = step && !m_step_prev;
      m_step_prev = step;
      if (!en) begin
        m_on = 0; m_read = 0; m_valid = 0;
      end else if (!m_on) begin
        m_on = 1; m_read = 1;
      end else if (m_read) begin
        m_data  = (m_idx == 5'd0) ? 32'd0 : rf[m_idx];
        m_didx  = m_idx;
        m_valid = 1;
        m_read  = 0;
        exp_q.push_back({m_didx, m_data});
      end else if (m_valid) begin
        if (bus.disp_ready) begin
          m_valid = 0;
          m_left  = int'(HOLD);
        end
      end else if (!pause) begin
        m_left--;
        if (m_left == 0) begin
          m_idx  = 5'((int'(m_idx) + 1) % 32);
          m_read = 1;
        end
      end else if (step_rise) begin
        m_idx  = 5'((int'(m_idx) + 1) % 32);
        m_read = 1;
      end
    end
    if (wr_en && wr_addr != 5'd0) rf[wr_addr] <= wr_data;
  end

  // ---------------- scoreboard / compare process ----------------
  bit mon_prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [36:0] e;
    if (cyc >= 1) begin
      check("busy", busy, m_on);
      check("dbg_idle", dbg_state == 2'd0, !m_on);
      check("disp_valid", bus.disp_valid, m_valid);
      check("rf_addr", bus.rf_addr, m_idx);
      check("disp_idx", bus.disp_idx, m_didx);
      check("disp_data", bus.disp_data, m_data);
      if (bus.disp_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL offer_unexpected cyc=%0d actual idx=%0d data=%0h expected none",
                   cyc, bus.disp_idx, bus.disp_data);
        end else begin
          e = exp_q.pop_front();
          check("offer", {bus.disp_idx, bus.disp_data}, e);
        end
      end
      mon_prev_valid = bus.disp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rise(output int at);
    int n = 0;
    while (bus.disp_valid && n < 400) begin @(negedge clk); n++; end
    while (!bus.disp_valid && n < 400) begin @(negedge clk); n++; end
    if (!bus.disp_valid) begin
      checks++; errors++;
      $display("FAIL wait_rise_timeout cyc=%0d actual no offer expected offer", cyc);
    end
    at = cyc;
  endtask

  task automatic rise_to(input logic [4:0] target, output int at);
    int k = 0;
    wait_rise(at);
    while (bus.disp_idx != target && k < 40) begin wait_rise(at); k++; end
    check("rise_to_idx", bus.disp_idx, target);
  endtask

  task automatic count_valid(input int n, output int hits);
    hits = 0;
    repeat (n) begin @(negedge clk); if (bus.disp_valid) hits++; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, hits, k;
    logic [4:0]  p_idx;
    logic [31:0] p_data;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rstn = 0; en = 0; pause = 0; step = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    bus.disp_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.disp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", bus.rf_addr, 5'd0);
    check("rst_data", bus.disp_data, 32'd0);
    check("rst_idx", bus.disp_idx, 5'd0);
    rstn = 1;

    // Scan with ready tied high: 0/0 then 1/1, six cycles apart.
    @(negedge clk);
    en = 1; t0 = cyc;
    wait_rise(t1);
    check("first_latency", t1 - t0, 2);
    check("first_idx", bus.disp_idx, 5'd0);
    check("first_data", bus.disp_data, 32'd0);
    t0 = t1;
    wait_rise(t1);
    check("period", t1 - t0, 6);
    check("second_idx", bus.disp_idx, 5'd1);
    check("second_data", bus.disp_data, 32'd1);

    // Backpressure on idx 3 for five edges.
    wait_rise(t0);
    @(negedge clk);
    bus.disp_ready = 0;
    wait_rise(t0);
    check("bp_idx", bus.disp_idx, 5'd3);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", bus.disp_valid, 1'b1);
      check("bp_data_stable", bus.disp_data, 32'd3);
    end
    bus.disp_ready = 1;
    wait_rise(t1);
    check("bp_period", t1 - t0, 11);
    check("bp_next_idx", bus.disp_idx, 5'd4);

    // Pause on idx 7, then single steps.
    rise_to(5'd7, t0);
    @(negedge clk);
    pause = 1;
    count_valid(100, hits);
    check("pause_no_offer", hits, 0);
    step = 1; t0 = cyc;
    wait_rise(t1);
    check("step_latency", t1 - t0, 2);
    check("step_idx", bus.disp_idx, 5'd8);
    check("step_data", bus.disp_data, 32'd8);
    count_valid(20, hits);
    check("step_held_once", hits, 0);
    step = 0; pause = 0;
    wait_rise(t0);
    check("resume_idx", bus.disp_idx, 5'd9);
    repeat (2) @(negedge clk);
    step = 1;
    @(negedge clk);
    step = 0;
    wait_rise(t1);
    check("unpaused_step_period", t1 - t0, 6);

    // Enable drop while holding idx 12.
    rise_to(5'd12, t0);
    repeat (2) @(negedge clk);
    en = 0;
    @(negedge clk);
    check("endrop_busy", busy, 1'b0);
    check("endrop_data", bus.disp_data, 32'd12);
    repeat (3) @(negedge clk);
    en = 1; t0 = cyc;
    wait_rise(t1);
    check("reen_latency", t1 - t0, 2);
    check("reen_idx", bus.disp_idx, 5'd12);

    // Wrap 31 -> 0.
    k = 0;
    p_idx = bus.disp_idx; p_data = bus.disp_data;
    wait_rise(t1);
    while (bus.disp_idx != 5'd0 && k < 40) begin
      p_idx = bus.disp_idx; p_data = bus.disp_data;
      wait_rise(t1); k++;
    end
    check("wrap_prev_idx", p_idx, 5'd31);
    check("wrap_prev_data", p_data, 32'd31);
    check("wrap_data", bus.disp_data, 32'd0);

    // RF write to r5 on the same edge that latches r5.
    rise_to(5'd4, t0);
    repeat (5) @(negedge clk);
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    wait_rise(t1);
    wr_en = 0;
    check("rw_same_idx", bus.disp_idx, 5'd5);
    check("rw_same_data", bus.disp_data, 32'd5);
    rise_to(5'd5, t1);
    check("rw_next_wrap", bus.disp_data, 32'hDEADBEEF);

    // Reset during the offer of idx 20.
    rise_to(5'd20, t0);
    rstn = 0;
    @(negedge clk);
    check("midrst_valid", bus.disp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", bus.disp_data, 32'd0);
    check("midrst_idx", bus.disp_idx, 5'd0);
    rstn = 1;
    wait_rise(t1);
    check("midrst_restart_idx", bus.disp_idx, 5'd0);

    // Random phase: model-checked every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.disp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      step    = ($urandom_range(0, 5) == 0);
      en      = ($urandom_range(0, 59) != 0);
      rstn    = ($urandom_range(0, 299) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
    end
    @(negedge clk);
    rstn = 1; en = 1; pause = 0; step = 0; wr_en = 0; bus.disp_ready = 1;
    repeat (20) @(negedge clk);
    check("offers_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
